// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer with one-shot and auto-reload modes.
// IRQ is the pending flag gated by the interrupt mask bit in CTRL.
module timer_counter #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] PRESET_RST = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Addr,
    input  logic             WE,
    input  logic [WIDTH-1:0] WD,
    output logic [WIDTH-1:0] RD,
    output logic             IRQ
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_nxt;
    logic [3:0]       ctrl, ctrl_nxt;
    logic [WIDTH-1:0] preset, preset_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic             irq_flag, flag_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ctrl     <= 4'd0;
            preset   <= PRESET_RST;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            ctrl     <= ctrl_nxt;
            preset   <= preset_nxt;
            count    <= count_nxt;
            irq_flag <= flag_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ctrl_nxt   = ctrl;
        preset_nxt = preset;
        count_nxt  = count;
        flag_nxt   = irq_flag;

        case (state)
            S_IDLE: if (ctrl[0]) state_nxt = S_LOAD;
            S_LOAD: begin
                count_nxt = preset;
                state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!ctrl[0]) begin
                    state_nxt = S_IDLE;
                end else if (count > ONE) begin
                    count_nxt = count - ONE;
                end else begin
                    // Expiry at 1 or 0 so a zero preset cannot wrap.
                    count_nxt = '0;
                    flag_nxt  = 1'b1;
                    state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (ctrl[2:1] == 2'b01) begin
                    flag_nxt  = 1'b0;
                    state_nxt = S_LOAD;
                end else begin
                    ctrl_nxt[0] = 1'b0;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Bus writes are applied last so they override the FSM's EN clear.
        if (WE) begin
            case (Addr)
                2'd0: begin
                    ctrl_nxt = WD[3:0];
                    flag_nxt = 1'b0;
                end
                2'd1:    preset_nxt = WD;
                default: ;
            endcase
        end
    end

    always_comb begin
        RD = '0;
        case (Addr)
            2'd0:    RD[3:0] = ctrl;
            2'd1:    RD = preset;
            2'd2:    RD = count;
            default: RD = '0;
        endcase
    end

    assign IRQ = irq_flag & ctrl[3];
endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: cycle model plus directed literal checks.
module tb_timer_counter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    timer_counter #(.WIDTH(32), .PRESET_RST(32'd0)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .WD(WD), .RD(RD), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 loading, 2 counting, 3 fired.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count;
    logic        m_flag;
    int          m_phase;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = 0;
        end else begin
            if (m_phase == 0) begin
                if (m_ctrl[0]) m_phase = 1;
            end else if (m_phase == 1) begin
                m_count = m_preset; m_phase = 2;
            end else if (m_phase == 2) begin
                if (!m_ctrl[0]) m_phase = 0;
                else if (m_count >= 2) m_count = m_count - 1;
                else begin m_count = 0; m_flag = 1'b1; m_phase = 3; end
            end else begin
                if (m_ctrl[2:1] == 2'b01) begin m_flag = 1'b0; m_phase = 1; end
                else begin m_ctrl[0] = 1'b0; m_phase = 0; end
            end
            if (WE && Addr == 2'd0) begin m_ctrl = WD[3:0]; m_flag = 1'b0; end
            if (WE && Addr == 2'd1) m_preset = WD;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("model_rd", RD, exp_rd(Addr));
            check("model_irq", {31'd0, IRQ}, {31'd0, m_flag & m_ctrl[3]});
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        WE = 1'b1; Addr = a; WD = d;
        @(posedge clk); #2;
        WE = 1'b0; WD = 32'd0;
    endtask

    task automatic peek(input string name, input logic [1:0] a, input logic [31:0] e);
        Addr = a; #1;
        check(name, RD, e);
    endtask

    initial begin
        int exp_c2 [5] = '{0, 3, 2, 1, 0};
        reset = 1'b1; Addr = 2'd0; WE = 1'b0; WD = 32'd0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        peek("rst_ctrl", 2'd0, 32'd0);
        peek("rst_preset", 2'd1, 32'd0);
        peek("rst_count", 2'd2, 32'd0);
        peek("rst_rsvd", 2'd3, 32'd0);
        check("rst_irq", {31'd0, IRQ}, 32'd0);

        // One-shot, PRESET=3
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            tick();
            peek("os_count", 2'd2, 32'(exp_c2[k-1]));
            check("os_irq", {31'd0, IRQ}, (k == 5) ? 32'd1 : 32'd0);
        end
        tick();
        peek("os_ctrl_en_clr", 2'd0, 32'h8);
        check("os_irq_held", {31'd0, IRQ}, 32'd1);
        tick();
        check("os_irq_held2", {31'd0, IRQ}, 32'd1);
        bus_write(2'd0, 32'h8);
        check("os_irq_ack", {31'd0, IRQ}, 32'd0);

        // Auto-reload, PRESET=2: period 4
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'hB);
        Addr = 2'd2;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("ar_irq", {31'd0, IRQ}, (k % 4 == 0) ? 32'd1 : 32'd0);
            if (k == 1) peek("ar_count", 2'd2, 32'd0);
            else begin
                case ((k - 2) % 4)
                    0:       peek("ar_count", 2'd2, 32'd2);
                    1:       peek("ar_count", 2'd2, 32'd1);
                    default: peek("ar_count", 2'd2, 32'd0);
                endcase
            end
        end
        bus_write(2'd0, 32'h0);
        repeat (4) tick();

        // EN cleared mid-count freezes COUNT, re-enable reloads
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);
        repeat (4) tick();
        bus_write(2'd0, 32'h8);
        repeat (3) tick();
        peek("frz_count", 2'd2, 32'd6);
        bus_write(2'd0, 32'h9);
        tick(); tick();
        peek("reload_count", 2'd2, 32'd10);
        bus_write(2'd1, 32'd20);
        tick();
        peek("preset_nofx", 2'd2, 32'd7);
        bus_write(2'd0, 32'h0);
        repeat (3) tick();

        // IM=0 masks IRQ; CTRL write clears the flag; COUNT not writable
        bus_write(2'd1, 32'd4);
        bus_write(2'd0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("mask_irq", {31'd0, IRQ}, 32'd0);
        end
        peek("mask_ctrl", 2'd0, 32'h0);
        bus_write(2'd2, 32'h55);
        peek("count_ro", 2'd2, 32'd0);
        bus_write(2'd0, 32'h8);
        check("mask_clr_irq", {31'd0, IRQ}, 32'd0);
        bus_write(2'd0, 32'h0);

        // PRESET=0 behaves like 1
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);
        tick(); tick();
        check("p0_irq_e2", {31'd0, IRQ}, 32'd0);
        tick();
        check("p0_irq_e3", {31'd0, IRQ}, 32'd1);
        bus_write(2'd0, 32'h0);
        tick();

        // Async reset mid-count
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);
        repeat (7) tick();
        peek("pre_rst_count", 2'd2, 32'd5);
        reset = 1'b1; #1;
        check("arst_count", RD, 32'd0);
        check("arst_irq", {31'd0, IRQ}, 32'd0);
        peek("arst_ctrl", 2'd0, 32'd0);
        peek("arst_preset", 2'd1, 32'd0);
        #1 reset = 1'b0;
        repeat (3) tick();
        peek("post_rst_count", 2'd2, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
